output_acc: RTL and testbench
=============================

# output_acc

Write-back collector at the output side of the systolic array. Captures one result vector of `OUTPUT_ACC_DEPTH` signed 16-bit values, optionally accumulating element-wise over several passes. On request, it drains the vector one word per cycle into the input accumulator's `nn` write port, so layer outputs become the next layer's inputs. Draining is throttled by a ready signal.

## Interface
- `OUTPUT_ACC_DEPTH`, 4: entries per vector; power of two, ≥2.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low. Asserting it (0) clears state immediately, and release is synchronous to `clk`.
- `output_acc_valid_data_in`  in  1  write strobe from the array/activation path.
- `output_acc_data_in`  in  16 signed  write value.
- `output_acc_accum_in`  in  1  qualifies a write: 1 = add to the stored entry, 0 = overwrite it.
- `output_acc_drain_in`  in  1  drain request.
- `output_acc_nn_ready_in`  in  1  downstream can accept a word this cycle.
- `output_acc_valid_data_nn_out`  out  1  drained word valid; connects to the input accumulator's nn valid.
- `output_acc_data_nn_out`  out  16 signed  drained word.
- `output_acc_full_out`  out  1  a complete vector is held and drainable.
- `output_acc_done_out`  out  1  one-cycle pulse coincident with the last drained word.
- `output_acc_overflow_out`  out  1  one-cycle pulse when a write is dropped.

## Operation
- Storage: `mem[OUTPUT_ACC_DEPTH]`, 16-bit signed. Reset does not clear it.
- Index registers: `wr_idx` and `rd_idx`, each `$clog2(OUTPUT_ACC_DEPTH)` bits.
- Flag `mem_vld`: set when a pass completes, cleared on reset and when a drain completes.
- States: IDLE, FILL, FULL, DRAIN. Reset state is IDLE with `wr_idx = rd_idx = 0` and `mem_vld = 0`.
- IDLE/FILL/FULL, write accepted:
  - Target is `mem[wr_idx]`; `wr_idx` increments and wraps to 0 after `DEPTH-1`.
  - Written value is `sum(mem[wr_idx], data)` if `accum_in && mem_vld`, else `data`. Accumulation in IDLE is treated as overwrite.
  - IDLE→FILL on the first write. FULL→FILL on a write, which starts a new pass.
  - The write that fills entry `DEPTH-1` moves FILL→FULL and sets `mem_vld`.
- FULL, `drain_in`=1 → DRAIN with `rd_idx = 0`. If a write arrives on the same edge, the drain wins, the write is dropped and `overflow_out` pulses.
- `drain_in` in IDLE/FILL/DRAIN is ignored; there is no overflow pulse.
- DRAIN, on each edge with `nn_ready_in`=1:
  - `valid_data_nn_out<=1`, `data_nn_out<=mem[rd_idx]`, `rd_idx` increments.
  - When `rd_idx == DEPTH-1`, also `done_out<=1`, state→IDLE, `mem_vld<=0`.
- DRAIN, edge with `nn_ready_in`=0: `valid_data_nn_out<=0`, `data_nn_out` holds, `rd_idx` holds.
- Writes during DRAIN are dropped; `overflow_out` pulses for one cycle per dropped write.
- Arithmetic: the 17-bit sign-extended sum is reduced to 16 bits per Configuration.
- `full_out` = (state==FULL), decoded from registered state only.

## Timing
- Reset values:
  - `valid_data_nn_out=0`, `data_nn_out=0`, `full_out=0`, `done_out=0`, `overflow_out=0`.
  - State IDLE, indices 0.
- Write latency: 1 cycle; `full_out` rises the cycle after the edge that stores entry `DEPTH-1`.
- Drain latency: `drain_in` sampled at edge k in FULL; `full_out` falls after edge k; the first word is valid after edge k+1, given ready.
- A drain takes `DEPTH` cycles minimum, plus one cycle per ready-low cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset mid-DRAIN or mid-FILL aborts immediately; the partial vector is discarded (`mem_vld=0`).

## Configuration
- `OUTPUT_ACC_SAT_EN` defined: the accumulate sum saturates to [-32768, 32767].
- `OUTPUT_ACC_SAT_EN` undefined: the sum wraps, keeping the low 16 bits (two's complement).
- Overwrite writes are unaffected by the macro.

## Test plan
All scenarios use DEPTH=4.
- **Basic fill and drain:** after reset all outputs are 0. Write 10, 20, 30, 40 → `full_out`=1. Pulse `drain_in` with ready=1 → nn words 10, 20, 30, 40 on four consecutive cycles, `done_out` with 40, then `full_out`=0.
- **Accumulate pass:** fill 1, 2, 3, 4, then write 100 ×4 with `accum_in`=1 → drain yields 101, 102, 103, 104.
- **Arithmetic limit:** fill 32000, -5, 0, 0, then accumulate 1000, -32768, 0, 0.
  - With `OUTPUT_ACC_SAT_EN`: drain 32767, -32768, 0, 0.
  - Without it: drain -32536, 32763, 0, 0.
- **Backpressure:** drain with ready=0 on the 2nd and 3rd drain cycles → valid is low on those cycles with data held; the sequence is 10, 20, 30, 40 with no loss or duplication.
- **Illegal requests:**
  - Write during DRAIN → `overflow_out` pulses once and the drained data is unchanged.
  - `drain_in` in FILL → ignored; no valid output.
  - Write and `drain_in` on the same edge in FULL → drain proceeds and `overflow_out`=1.
- **Reset mid-drain:** assert `rst`=0 after the 2nd word → outputs go to 0 asynchronously and state is IDLE. A later fill of 5, 6, 7, 8 with `accum_in`=1 drains as 5, 6, 7, 8, since accumulation with no valid vector is treated as overwrite.

Source files
------------

// File: rtl/output_acc.sv
// output_acc -- write-back collector at the output side of the systolic array.
//
// Captures one vector of OUTPUT_ACC_DEPTH signed 16-bit results, optionally
// accumulating element-wise over several passes, then drains it one word
// per cycle into the input accumulator's nn write port, throttled by ready.
//
// Optional feature macro: OUTPUT_ACC_SAT_EN
//   defined   : accumulate sums saturate to [-32768, 32767]
//   undefined : accumulate sums wrap (low 16 bits, two's complement)
//
// Ports:
//   clk                          clock, rising edge
//   rst                          async reset, active low
//   output_acc_valid_data_in     write strobe
//   output_acc_data_in           signed write value
//   output_acc_accum_in          1 = add to stored entry, 0 = overwrite
//   output_acc_drain_in          drain request (honoured only when FULL)
//   output_acc_nn_ready_in       downstream accepts a word this cycle
//   output_acc_valid_data_nn_out drained word valid
//   output_acc_data_nn_out       drained word
//   output_acc_full_out          complete vector held and drainable
//   output_acc_done_out          pulse with the last drained word
//   output_acc_overflow_out      pulse when a write is dropped
module output_acc #(
  parameter int OUTPUT_ACC_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               output_acc_valid_data_in,
  input  logic signed [15:0] output_acc_data_in,
  input  logic               output_acc_accum_in,
  input  logic               output_acc_drain_in,
  input  logic               output_acc_nn_ready_in,
  output logic               output_acc_valid_data_nn_out,
  output logic signed [15:0] output_acc_data_nn_out,
  output logic               output_acc_full_out,
  output logic               output_acc_done_out,
  output logic               output_acc_overflow_out
);

  localparam int AW = (OUTPUT_ACC_DEPTH > 1) ? $clog2(OUTPUT_ACC_DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(OUTPUT_ACC_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_t;

  state_t state, state_nxt;

  logic signed [15:0] mem [OUTPUT_ACC_DEPTH];
  logic [AW-1:0]      wr_idx, rd_idx;
  logic               mem_vld;

  logic               wr_en, drop, drain_go, rd_fire;
  logic               pass_done, rd_last;
  logic signed [16:0] sum17;
  logic signed [15:0] sum16, wr_val;

  // ---------------------------------------------------------------------
  // Next-state / control decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    drop      = 1'b0;
    drain_go  = 1'b0;
    rd_fire   = 1'b0;
    case (state)
      IDLE, FILL: begin
        if (output_acc_valid_data_in) begin
          wr_en     = 1'b1;
          state_nxt = (wr_idx == LAST) ? FULL : FILL;
        end
      end
      FULL: begin
        // A drain request beats a same-edge write; the write is dropped.
        if (output_acc_drain_in) begin
          drain_go  = 1'b1;
          drop      = output_acc_valid_data_in;
          state_nxt = DRAIN;
        end else if (output_acc_valid_data_in) begin
          wr_en     = 1'b1;
          state_nxt = (wr_idx == LAST) ? FULL : FILL;
        end
      end
      DRAIN: begin
        drop = output_acc_valid_data_in;
        if (output_acc_nn_ready_in) begin
          rd_fire = 1'b1;
          if (rd_idx == LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pass_done = wr_en && (wr_idx == LAST);
  assign rd_last   = rd_fire && (rd_idx == LAST);

  // ---------------------------------------------------------------------
  // Write datapath: 17-bit sum so the overflow is visible before reduction
  // ---------------------------------------------------------------------
  assign sum17 = {mem[wr_idx][15], mem[wr_idx]} +
                 {output_acc_data_in[15], output_acc_data_in};

`ifdef OUTPUT_ACC_SAT_EN
  // Top two bits disagree only when the true sum left the 16-bit range.
  always_comb begin
    sum16 = sum17[15:0];
    if (sum17[16] != sum17[15])
      sum16 = sum17[16] ? 16'sh8000 : 16'sh7fff;
  end
`else
  assign sum16 = sum17[15:0];
`endif

  // Without a completed vector there is nothing meaningful to add to.
  assign wr_val = (output_acc_accum_in && mem_vld) ? sum16 : output_acc_data_in;

  // Storage is intentionally not reset; mem_vld guards its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_val;
  end

  // ---------------------------------------------------------------------
  // State, indices and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                        <= IDLE;
      wr_idx                       <= '0;
      rd_idx                       <= '0;
      mem_vld                      <= 1'b0;
      output_acc_valid_data_nn_out <= 1'b0;
      output_acc_data_nn_out       <= '0;
      output_acc_done_out          <= 1'b0;
      output_acc_overflow_out      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_en)     wr_idx  <= wr_idx + 1'b1;
      if (pass_done) mem_vld <= 1'b1;
      if (drain_go)  rd_idx  <= '0;
      else if (rd_fire) rd_idx <= rd_idx + 1'b1;
      if (rd_last)   mem_vld <= 1'b0;
      output_acc_valid_data_nn_out <= rd_fire;
      if (rd_fire) output_acc_data_nn_out <= mem[rd_idx];
      output_acc_done_out     <= rd_last;
      output_acc_overflow_out <= drop;
    end
  end

  assign output_acc_full_out = (state == FULL);

endmodule

// File: tb/tb_output_acc.sv
// tb_output_acc -- randomized/directed scoreboard bench for output_acc.
// Stimulus tasks update a vector-level reference model and push expected
// drained words into a queue; a forked monitor pops and compares whenever
// the DUT presents a valid nn word.
module tb_output_acc;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               wv  = 1'b0;
  logic signed [15:0] wd  = '0;
  logic               acc = 1'b0;
  logic               drn = 1'b0;
  logic               rdy = 1'b1;
  logic               ov;
  logic signed [15:0] od;
  logic               full, done, ovf;

  always #5 clk = ~clk;

  output_acc #(.OUTPUT_ACC_DEPTH(4)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .output_acc_valid_data_in     (wv),
    .output_acc_data_in           (wd),
    .output_acc_accum_in          (acc),
    .output_acc_drain_in          (drn),
    .output_acc_nn_ready_in       (rdy),
    .output_acc_valid_data_nn_out (ov),
    .output_acc_data_nn_out       (od),
    .output_acc_full_out          (full),
    .output_acc_done_out          (done),
    .output_acc_overflow_out      (ovf)
  );

  typedef struct {int d; bit last;} exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;
  int mv[4];
  bit mvld = 1'b0;
  int mcnt = 0;
  int words = 0, done_seen = 0, ovf_seen = 0, exp_ovf = 0;
  int last_data = 0;

  function automatic int fix16(int s);
    logic signed [15:0] t;
`ifdef OUTPUT_ACC_SAT_EN
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    t = s[15:0];
    return int'(t);
`endif
  endfunction

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic mon();
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        last_data = 0;
        continue;
      end
      if (ov) begin
        words++;
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_word: got %0d expected no valid word at %0t", od, $time);
        end else begin
          e = q.pop_front();
          chk("nn_data", int'(od), e.d);
          chk("done_with_word", int'(done), int'(e.last));
        end
        last_data = int'(od);
      end else begin
        chk("hold_data", int'(od), last_data);
        chk("done_idle", int'(done), 0);
      end
      if (ovf)  ovf_seen++;
      if (done) done_seen++;
    end
  endtask

  // Caller is just past a negedge; returns just past the next negedge.
  task automatic wr(int d, bit a);
    wv = 1'b1; wd = 16'(d); acc = a;
    mv[mcnt] = (a && mvld) ? fix16(mv[mcnt] + d) : d;
    mcnt = (mcnt + 1) % 4;
    if (mcnt == 0) mvld = 1'b1;
    @(negedge clk);
    wv = 1'b0; acc = 1'b0;
  endtask

  task automatic fill4(int a0, int a1, int a2, int a3, bit a);
    wr(a0, a); wr(a1, a); wr(a2, a); wr(a3, a);
    chk("full_set", int'(full), 1);
  endtask

  task automatic push_vec();
    for (int i = 0; i < 4; i++) q.push_back('{mv[i], i == 3});
    mvld = 1'b0;
  endtask

  // pat bit k = 1 holds ready low on drain cycle k; wr_at injects a write.
  task automatic drain(int pat, int wr_at, bit same_wr);
    int target, cyc;
    if (same_wr) begin
      wv = 1'b1; wd = 16'($urandom); exp_ovf++;
    end
    drn = 1'b1;
    push_vec();
    @(negedge clk);
    drn = 1'b0; wv = 1'b0;
    chk("full_clear_on_drain", int'(full), 0);
    target = done_seen + 1;
    cyc = 0;
    while (done_seen < target && cyc < 64) begin
      rdy = ((pat >> cyc) & 1) == 0;
      if (cyc == wr_at) begin
        wv = 1'b1; wd = 16'($urandom); exp_ovf++;
      end
      @(negedge clk);
      wv = 1'b0; rdy = 1'b1;
      cyc++;
    end
    if (done_seen < target) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d done pulses expected %0d", done_seen, target);
    end
    chk("full_after_done", int'(full), 0);
    chk("overflow_count", ovf_seen, exp_ovf);
  endtask

  initial begin
    int base, cyc, npass, d;
    fork mon(); join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(ov), 0);
    chk("rst_data", int'(od), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic fill and drain
    fill4(10, 20, 30, 40, 1'b0);
    drain(0, -1, 1'b0);

    // Accumulate pass
    fill4(1, 2, 3, 4, 1'b0);
    fill4(100, 100, 100, 100, 1'b1);
    drain(0, -1, 1'b0);

    // Arithmetic limit
    fill4(32000, -5, 0, 0, 1'b0);
    fill4(1000, -32768, 0, 0, 1'b1);
    drain(0, -1, 1'b0);

    // Backpressure on 2nd and 3rd drain cycles
    fill4(10, 20, 30, 40, 1'b0);
    drain(32'h6, -1, 1'b0);

    // Write during drain
    fill4(11, 22, 33, 44, 1'b0);
    drain(0, 1, 1'b0);

    // Drain request in FILL is ignored
    wr(7, 1'b0); wr(8, 1'b0);
    drn = 1'b1;
    @(negedge clk);
    drn = 1'b0;
    chk("fill_not_full", int'(full), 0);
    wr(9, 1'b0); wr(10, 1'b0);
    chk("full_after_ignored_drain", int'(full), 1);
    drain(0, -1, 1'b0);

    // Write and drain on the same edge in FULL
    fill4(5, 6, 7, 8, 1'b0);
    drain(0, -1, 1'b1);

    // Reset mid-drain
    fill4(10, 20, 30, 40, 1'b0);
    base = words;
    drn = 1'b1;
    push_vec();
    @(negedge clk);
    drn = 1'b0;
    cyc = 0;
    while (words < base + 2 && cyc < 20) begin
      @(posedge clk); #3;
      cyc++;
    end
    chk("words_before_reset", words - base, 2);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", int'(ov), 0);
    chk("async_rst_data", int'(od), 0);
    chk("async_rst_full", int'(full), 0);
    chk("async_rst_done", int'(done), 0);
    q.delete();
    mvld = 1'b0; mcnt = 0;
    @(posedge clk); #2;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fill4(5, 6, 7, 8, 1'b1);
    drain(0, -1, 1'b0);

    // Randomized passes
    for (int it = 0; it < 25; it++) begin
      npass = $urandom_range(1, 3);
      for (int p = 0; p < npass; p++) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          d = int'($urandom_range(0, 65535)) - 32768;
          wr(d, 1'($urandom_range(0, 1)));
        end
        chk("rand_full", int'(full), 1);
      end
      drain(int'($urandom), int'($urandom_range(0, 5)) - 2, 1'($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("final_overflow_count", ovf_seen, exp_ovf);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
